div_unit: RTL and testbench

// - Iterative signed 32-bit divider (MIPS DIV) sitting between A/B registers and HI/LO write muxes.
// - Consumes AOut (dividend) and BOut (divisor) on a control-unit start pulse.
// - Produces the quotient (LO), the remainder (HI) and a divide-by-zero flag for the control unit.
// - Control unit holds its DIV state until done or div_zero.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_step.sv | 27 ++
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative signed divider: FSM state encoding
// and the default operand width / iteration counter width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one and
// subtract the divisor magnitude from the widened partial remainder when it fits.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   sh_rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // The shifted remainder is WIDTH+1 bits; when its top bit is set it is
  // always >= the divisor, and the true difference then fits in WIDTH bits.
  always_comb begin
    sh_rem = {rem_i, quo_i[WIDTH-1]};
    ge     = sh_rem[WIDTH] | (sh_rem[WIDTH-1:0] >= dvsr_i);
    diff   = sh_rem[WIDTH-1:0] - dvsr_i;
    rem_o  = ge ? diff : sh_rem[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed divider (MIPS DIV semantics): quotient on lo, remainder
// on hi, truncation toward zero, remainder takes the dividend's sign.
// Operands are converted to magnitudes, divided by restoring division over
// WIDTH cycles, then sign-corrected in FIX. All outputs are registered
// decodes of the current state, so they lag the state by one edge.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output div_state_e       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             busy_q, done_q, div_zero_q;
  logic             busy_d, done_d, div_zero_d;
  logic             accept, dvs_zero, last_iter;

  // A new request is only taken when no operation is in flight.
  always_comb begin
    accept    = start && ((state_q == DIV_IDLE) || (state_q == DIV_DONE));
    dvs_zero  = (divisor == '0);
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    abs_dvd   = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    abs_dvs   = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  end

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_n),
    .quo_o  (quo_n)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (accept && !dvs_zero) state_d = DIV_CALC;
        else                     state_d = DIV_IDLE;
      end
      DIV_CALC: if (last_iter) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Output decode from the current state; registered below.
  always_comb begin
    busy_d     = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    done_d     = (state_q == DIV_DONE);
    div_zero_d = accept && dvs_zero;
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, sign-fix in FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (accept && !dvs_zero) begin
        rem_q   <= '0;
        quo_q   <= abs_dvd;
        dvsr_q  <= abs_dvs;
        cnt_q   <= '0;
        q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg_q <= dividend[WIDTH-1];
      end else if (state_q == DIV_CALC) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == DIV_FIX) begin
        lo_q <= q_neg_q ? (~quo_q + 1'b1) : quo_q;
        hi_q <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
      end
    end
  end

  assign lo        = lo_q;
  assign hi        = hi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit. Expected values are hand-computed
// MIPS DIV results (truncate toward zero, remainder follows dividend sign).
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         busy;
  logic         done;
  logic         div_zero;
  div_state_e   dbg_state;

  int n_cmp;
  int n_bad;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present operands at the falling edge, sampled on the next rising
  // edge (edge 0); return #1 after edge 0 with inputs scrambled so the DUT
  // must rely on its latched copies.
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom();
    divisor  = $urandom_range(1, 1000);
  endtask

  // Wait for done, counting rising edges after edge 0. busy must be high on
  // every edge before done and low on the done edge.
  task automatic wait_done(output int lat, output int busy_bad);
    lat      = -1;
    busy_bad = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({lo, hi, busy, done, div_zero} !== '0 || dbg_state !== DIV_IDLE) begin
      n_bad++;
      $display("FAIL reset_outputs: lo=%h hi=%h busy=%b done=%b dz=%b state=%0d, want all 0 / IDLE",
               lo, hi, busy, done, div_zero, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bb;
    pulse_start(32'd7, 32'd2);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_edge0: busy=%b want 0", busy);
    end
    wait_done(lat, bb);
    n_cmp++;
    if (lat !== 34) begin
      n_bad++;
      $display("FAIL basic_latency: done at edge %0d want 34", lat);
    end
    n_cmp++;
    if (bb !== 0) begin
      n_bad++;
      $display("FAIL basic_busy: %0d bad busy samples want 0", bb);
    end
    n_cmp++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      n_bad++;
      $display("FAIL basic_7div2: lo=%h hi=%h want 00000003/00000001", lo, hi);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'd3) begin
      n_bad++;
      $display("FAIL basic_after: done=%b busy=%b lo=%h want 0/0/00000003", done, busy, lo);
    end
  endtask

  task automatic test_signs;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [W-1:0] el [5];
    logic [W-1:0] eh [5];
    int lat, bb;
    va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          el[0] = 32'hFFFF_FFFD; eh[0] = 32'hFFFF_FFFF;
    va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE;  el[1] = 32'hFFFF_FFFD; eh[1] = 32'd1;
    va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF;  el[2] = 32'h8000_0000; eh[2] = 32'd0;
    va[3] = 32'd5;         vb[3] = 32'd9;          el[3] = 32'd0;         eh[3] = 32'd5;
    va[4] = 32'hFFFF_FFF9; vb[4] = 32'hFFFF_FFFE;  el[4] = 32'd3;         eh[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      pulse_start(va[i], vb[i]);
      wait_done(lat, bb);
      n_cmp++;
      if (lat !== 34 || lo !== el[i] || hi !== eh[i]) begin
        n_bad++;
        $display("FAIL signs_%0d: %h/%h lat=%0d lo=%h hi=%h want lat=34 lo=%h hi=%h",
                 i, va[i], vb[i], lat, lo, hi, el[i], eh[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bb, dz_cnt, dn_cnt;
    pulse_start(32'd7, 32'd2);
    wait_done(lat, bb);
    pulse_start(32'd12, 32'd0);
    n_cmp++;
    if (div_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL dz_pulse: div_zero=%b want 1", div_zero);
    end
    dz_cnt = 1;
    dn_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (div_zero) dz_cnt++;
      if (done || busy) dn_cnt++;
    end
    n_cmp++;
    if (dz_cnt !== 1 || dn_cnt !== 0) begin
      n_bad++;
      $display("FAIL dz_once: div_zero cycles=%0d done/busy cycles=%0d want 1/0", dz_cnt, dn_cnt);
    end
    n_cmp++;
    if (lo !== 32'd3 || hi !== 32'd1 || dbg_state !== DIV_IDLE) begin
      n_bad++;
      $display("FAIL dz_retain: lo=%h hi=%h state=%0d want 3/1/IDLE", lo, hi, dbg_state);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    pulse_start(32'd100, 32'd7);
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (e == 10) begin
        start = 1'b1; dividend = 32'd1; divisor = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = e;
        break;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (lat !== 34 || lo !== 32'd14 || hi !== 32'd2) begin
      n_bad++;
      $display("FAIL ignore_start: lat=%0d lo=%h hi=%h want 34/0000000e/00000002", lat, lo, hi);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bb;
    pulse_start(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({lo, hi, busy, done, div_zero} !== '0 || dbg_state !== DIV_IDLE) begin
      n_bad++;
      $display("FAIL reset_mid: lo=%h hi=%h busy=%b done=%b dz=%b state=%0d want all 0 / IDLE",
               lo, hi, busy, done, div_zero, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    pulse_start(32'd9, 32'd3);
    wait_done(lat, bb);
    n_cmp++;
    if (lat !== 34 || lo !== 32'd3 || hi !== 32'd0 || bb !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_9div3: lat=%0d lo=%h hi=%h busybad=%0d want 34/3/0/0", lat, lo, hi, bb);
    end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, bb;
    pulse_start(32'd20, 32'd6);
    repeat (33) @(posedge clk);
    // The divider sits in DONE between edges 33 and 34; start is taken there.
    @(negedge clk);
    start = 1'b1; dividend = 32'd21; divisor = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat1 = done ? 34 : -1;
    n_cmp++;
    if (lat1 !== 34 || lo !== 32'd3 || hi !== 32'd2) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b lo=%h hi=%h want 1/3/2", done, lo, hi);
    end
    wait_done(lat2, bb);
    n_cmp++;
    if (lat2 !== 34 || lo !== 32'd5 || hi !== 32'd1 || bb !== 0) begin
      n_bad++;
      $display("FAIL b2b_second: lat=%0d lo=%h hi=%h busybad=%0d want 34/5/1/0", lat2, lo, hi, bb);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
